sa_output_drain: RTL and testbench

//  Writeback stage downstream of the systolic array. Accepts one accumulator row per beat from the array.

---
 rtl/sa_output_drain_pkg.sv | 40 ++++
 rtl/sa_output_drain_if.sv | 39 +++
 rtl/sa_output_drain_row_fifo.sv | 70 +++++++
 rtl/sa_output_drain.sv | 129 ++++++++++++
 tb/tb_sa_output_drain.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sa_output_drain_pkg.sv
// Shared constants, FSM encoding and the requantization helper for the
// systolic-array output drain.
package sa_output_drain_pkg;

    localparam int DIM        = 4;
    localparam int INT_BITS   = 8;
    localparam int FRAC_BITS  = 8;
    localparam int DW         = INT_BITS + FRAC_BITS;
    localparam int ACC_BITS   = 32;
    localparam int FIFO_DEPTH = 4;

    localparam logic [33:0] TILE_BYTES = 34'(DIM * DIM * DW / 8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam logic signed [ACC_BITS:0] RQ_HALF = (ACC_BITS + 1)'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_BITS:0] RQ_MAX  = (ACC_BITS + 1)'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_BITS:0] RQ_MIN  = (ACC_BITS + 1)'(-(2 ** (DW - 1)));

    // One extra bit of headroom so adding the rounding half never wraps.
    function automatic logic [DW-1:0] requant(input logic [ACC_BITS-1:0] acc);
        logic signed [ACC_BITS:0] sum;
        logic signed [ACC_BITS:0] r;
        sum = $signed({acc[ACC_BITS-1], acc}) + RQ_HALF;
        r   = sum >>> FRAC_BITS;
        if (r > RQ_MAX) begin
            r = RQ_MAX;
        end else if (r < RQ_MIN) begin
            r = RQ_MIN;
        end
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/sa_output_drain_if.sv
// Handshake bundle between the drain, the core control FSM, the array and
// the vec_out writer.
interface sa_output_drain_if;
    import sa_output_drain_pkg::*;

    logic                    start_valid;
    logic                    start_ready;
    logic [63:0]             start_out_addr;
    logic                    done_valid;
    logic                    done_ready;
    logic [DIM*ACC_BITS-1:0] acc_in;
    logic                    acc_in_valid;
    logic                    acc_in_ready;
    logic                    vec_out_req_valid;
    logic                    vec_out_req_ready;
    logic [33:0]             vec_out_req_len;
    logic [63:0]             vec_out_req_addr_address;
    logic                    vec_out_isFlushed;
    logic                    vec_out_data_valid;
    logic                    vec_out_data_ready;
    logic [DIM*DW-1:0]       vec_out_data;

    modport master (
        input  start_valid, start_out_addr, done_ready, acc_in, acc_in_valid,
               vec_out_req_ready, vec_out_isFlushed, vec_out_data_ready,
        output start_ready, done_valid, acc_in_ready, vec_out_req_valid,
               vec_out_req_len, vec_out_req_addr_address, vec_out_data_valid,
               vec_out_data
    );

    modport slave (
        output start_valid, start_out_addr, done_ready, acc_in, acc_in_valid,
               vec_out_req_ready, vec_out_isFlushed, vec_out_data_ready,
        input  start_ready, done_valid, acc_in_ready, vec_out_req_valid,
               vec_out_req_len, vec_out_req_addr_address, vec_out_data_valid,
               vec_out_data
    );

endinterface

// File: rtl/sa_output_drain_row_fifo.sv
// Show-ahead row FIFO: dout always presents the oldest entry while not empty.
module sa_row_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       areset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; nothing reads it while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sa_output_drain.sv
// Writeback stage: requantizes accumulator rows, buffers them and streams one
// DIM-row tile into a single vec_out write transaction.
//
// state  | meaning
// IDLE   | waiting for start; start_ready high
// REQ    | presenting the write request until accepted
// STREAM | accepting acc rows and draining buffered rows to vec_out
// FLUSH  | all rows sent; waiting for the writer to commit
// DONE   | done_valid high until the core acknowledges
module sa_output_drain
    import sa_output_drain_pkg::*;
(
    input  logic          clock,
    input  logic          areset,
    sa_output_drain_if.master bus
);
    localparam int RCW = $clog2(DIM + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_e          state_q, state_d;
    logic [RCW-1:0]  rows_in_q, rows_in_d;
    logic [RCW-1:0]  rows_out_q, rows_out_d;
    logic [63:0]     addr_q, addr_d;

    logic [DIM*DW-1:0] row_quant;
    logic [DIM*DW-1:0] fifo_dout;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              acc_ready;
    logic              data_valid;
    logic              acc_fire;
    logic              data_fire;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        assign row_quant[i*DW +: DW] = requant(bus.acc_in[i*ACC_BITS +: ACC_BITS]);
    end

    // The FIFO entry doubles as the requant register, so a row accepted at
    // one edge is visible at the output right after it.
    sa_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DIM * DW)
    ) u_fifo (
        .clock  (clock),
        .areset (areset),
        .push   (acc_fire),
        .din    (row_quant),
        .pop    (data_fire),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign acc_ready  = (state_q == ST_STREAM) && (rows_in_q < RCW'(DIM))
                        && (fifo_count < FCW'(FIFO_DEPTH)) && !fifo_full;
    assign data_valid = (state_q == ST_STREAM) && !fifo_empty;
    assign acc_fire   = bus.acc_in_valid && acc_ready;
    assign data_fire  = data_valid && bus.vec_out_data_ready;

    assign bus.start_ready              = (state_q == ST_IDLE);
    assign bus.done_valid               = (state_q == ST_DONE);
    assign bus.acc_in_ready             = acc_ready;
    assign bus.vec_out_req_valid        = (state_q == ST_REQ);
    assign bus.vec_out_req_len          = (state_q == ST_REQ) ? TILE_BYTES : '0;
    assign bus.vec_out_req_addr_address = addr_q;
    assign bus.vec_out_data_valid       = data_valid;
    assign bus.vec_out_data             = data_valid ? fifo_dout : '0;

    always_comb begin
        state_d    = state_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q;
        addr_d     = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    addr_d     = bus.start_out_addr;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.vec_out_req_ready) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (acc_fire) begin
                    rows_in_d = rows_in_q + RCW'(1);
                end
                if (data_fire) begin
                    rows_out_d = rows_out_q + RCW'(1);
                    if (rows_out_q == RCW'(DIM - 1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.vec_out_isFlushed) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_sa_output_drain.sv
// Directed self-checking bench for sa_output_drain (DIM=4, DW=16, Q8.8, ACC=32).
module tb_sa_output_drain;
    import sa_output_drain_pkg::*;

    logic clock = 1'b0;
    logic areset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    sa_output_drain_if bus ();

    sa_output_drain dut (
        .clock  (clock),
        .areset (areset),
        .bus    (bus)
    );

    logic [DIM*ACC_BITS-1:0] row_acc [4];
    logic [DIM*DW-1:0]       row_exp [4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a row until it is accepted; gives up after a fixed budget.
    task automatic send_row(input logic [DIM*ACC_BITS-1:0] row, input string tag);
        logic ok;
        ok = 1'b0;
        bus.acc_in       = row;
        bus.acc_in_valid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.acc_in_ready) ok = 1'b1;
            step();
        end
        bus.acc_in_valid = 1'b0;
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 64'(bus.start_ready), 64'd1);
        chk({tag, "_done_valid"},  64'(bus.done_valid), 64'd0);
        chk({tag, "_acc_ready"},   64'(bus.acc_in_ready), 64'd0);
        chk({tag, "_req_valid"},   64'(bus.vec_out_req_valid), 64'd0);
        chk({tag, "_req_len"},     64'(bus.vec_out_req_len), 64'd0);
        chk({tag, "_req_addr"},    bus.vec_out_req_addr_address, 64'd0);
        chk({tag, "_data_valid"},  64'(bus.vec_out_data_valid), 64'd0);
        chk({tag, "_data"},        bus.vec_out_data, 64'd0);
    endtask

    task automatic start_tile(input logic [63:0] addr, input string tag);
        bus.start_out_addr = addr;
        bus.start_valid    = 1'b1;
        step();
        bus.start_valid    = 1'b0;
        chk({tag, "_req_valid"}, 64'(bus.vec_out_req_valid), 64'd1);
        chk({tag, "_req_len"},   64'(bus.vec_out_req_len), 64'd32);
        chk({tag, "_req_addr"},  bus.vec_out_req_addr_address, addr);
        chk({tag, "_acc_ready_in_req"}, 64'(bus.acc_in_ready), 64'd0);
        bus.vec_out_req_ready = 1'b1;
        step();
        bus.vec_out_req_ready = 1'b0;
        chk({tag, "_req_dropped"}, 64'(bus.vec_out_req_valid), 64'd0);
        chk({tag, "_acc_ready_stream"}, 64'(bus.acc_in_ready), 64'd1);
    endtask

    initial begin
        logic seen;

        row_acc[0] = {32'h7FFFFFFF, 32'hFFFFFF80, 32'h00000080, 32'h00018000};
        row_exp[0] = {16'h7FFF, 16'h0000, 16'h0001, 16'h0180};
        row_acc[1] = {32'h00000100, 32'h00000000, 32'hFFFF0000, 32'h80000000};
        row_exp[1] = {16'h0001, 16'h0000, 16'hFF00, 16'h8000};
        row_acc[2] = {32'hFF800000, 32'h007FFF7F, 32'hFFFFFE7F, 32'h00000180};
        row_exp[2] = {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0002};
        row_acc[3] = {32'h00000000, 32'hFFFFFF7F, 32'h000012C0, 32'h00123456};
        row_exp[3] = {16'h0000, 16'hFFFF, 16'h0013, 16'h1234};

        areset                 = 1'b1;
        bus.start_valid        = 1'b0;
        bus.start_out_addr     = '0;
        bus.done_ready         = 1'b0;
        bus.acc_in             = '0;
        bus.acc_in_valid       = 1'b0;
        bus.vec_out_req_ready  = 1'b0;
        bus.vec_out_isFlushed  = 1'b0;
        bus.vec_out_data_ready = 1'b0;
        repeat (3) step();
        areset = 1'b0;
        step();
        chk_reset_outputs("reset");

        // Tile 1: request held off two cycles while a row is offered.
        bus.start_out_addr = 64'h1000;
        bus.start_valid    = 1'b1;
        step();
        bus.start_valid    = 1'b0;
        bus.acc_in         = row_acc[0];
        bus.acc_in_valid   = 1'b1;
        chk("t1_req_valid", 64'(bus.vec_out_req_valid), 64'd1);
        chk("t1_req_len",   64'(bus.vec_out_req_len), 64'd32);
        chk("t1_req_addr",  bus.vec_out_req_addr_address, 64'h1000);
        chk("t1_start_ready_busy", 64'(bus.start_ready), 64'd0);
        for (int c = 0; c < 2; c++) begin
            chk("t1_acc_ready_in_req", 64'(bus.acc_in_ready), 64'd0);
            step();
            chk("t1_req_held", 64'(bus.vec_out_req_valid), 64'd1);
        end
        bus.acc_in_valid      = 1'b0;
        bus.vec_out_req_ready = 1'b1;
        step();
        bus.vec_out_req_ready = 1'b0;
        chk("t1_req_dropped", 64'(bus.vec_out_req_valid), 64'd0);
        chk("t1_acc_ready_stream", 64'(bus.acc_in_ready), 64'd1);

        send_row(row_acc[0], "t1_row0_accept");
        chk("t1_first_valid", 64'(bus.vec_out_data_valid), 64'd1);
        chk("t1_first_data", bus.vec_out_data, row_exp[0]);
        for (int k = 1; k < 4; k++) send_row(row_acc[k], "t1_row_accept");
        chk("t1_full_refuse", 64'(bus.acc_in_ready), 64'd0);

        // A fifth beat is offered while the output is stalled and then drained.
        bus.acc_in       = row_acc[1];
        bus.acc_in_valid = 1'b1;
        repeat (3) step();
        chk("t1_fifth_refused", 64'(bus.acc_in_ready), 64'd0);
        chk("t1_held_data", bus.vec_out_data, row_exp[0]);
        bus.vec_out_data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1_out_valid", 64'(bus.vec_out_data_valid), 64'd1);
            chk("t1_out_data", bus.vec_out_data, row_exp[k]);
            chk("t1_fifth_still_refused", 64'(bus.acc_in_ready), 64'd0);
            step();
        end
        bus.vec_out_data_ready = 1'b0;
        bus.acc_in_valid       = 1'b0;
        chk("t1_drained_valid", 64'(bus.vec_out_data_valid), 64'd0);

        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done_valid) seen = 1'b1;
            step();
        end
        chk("t1_no_done_before_flush", 64'(seen), 64'd0);
        bus.vec_out_isFlushed = 1'b1;
        step();
        bus.vec_out_isFlushed = 1'b0;
        chk("t1_done_after_flush", 64'(bus.done_valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t1_done_held", 64'(bus.done_valid), 64'd1);
            chk("t1_start_blocked", 64'(bus.start_ready), 64'd0);
        end
        bus.done_ready = 1'b1;
        step();
        bus.done_ready = 1'b0;
        chk("t1_done_cleared", 64'(bus.done_valid), 64'd0);
        chk("t1_back_idle", 64'(bus.start_ready), 64'd1);

        // Tile abandoned by reset after two rows.
        start_tile(64'h3000, "ab");
        send_row(row_acc[2], "ab_row0_accept");
        send_row(row_acc[3], "ab_row1_accept");
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        chk_reset_outputs("ab_reset");

        // Tile 2: each row drained right after it lands, in a new order.
        start_tile(64'h2000, "t2");
        for (int k = 0; k < 4; k++) begin
            send_row(row_acc[3-k], "t2_row_accept");
            chk("t2_out_valid", 64'(bus.vec_out_data_valid), 64'd1);
            chk("t2_out_data", bus.vec_out_data, row_exp[3-k]);
            bus.vec_out_data_ready = 1'b1;
            step();
            bus.vec_out_data_ready = 1'b0;
        end
        chk("t2_drained_valid", 64'(bus.vec_out_data_valid), 64'd0);
        chk("t2_addr_kept", bus.vec_out_req_addr_address, 64'h2000);
        chk("t2_no_early_done", 64'(bus.done_valid), 64'd0);
        bus.vec_out_isFlushed = 1'b1;
        step();
        bus.vec_out_isFlushed = 1'b0;
        chk("t2_done", 64'(bus.done_valid), 64'd1);
        bus.done_ready = 1'b1;
        step();
        bus.done_ready = 1'b0;
        chk("t2_back_idle", 64'(bus.start_ready), 64'd1);
        chk("t2_done_cleared", 64'(bus.done_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
